// File: rtl/fifo_byte_serializer_pkg.sv
// Shared types and helpers for the word-FIFO to byte-stream serializer.
package interconnect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } serializer_state_t;

    function automatic int unsigned calc_beats(input int unsigned data_width,
                                               input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

    // A single-beat word still needs a 1-bit counter so the logic stays well-formed.
    function automatic int unsigned calc_cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// FIFO read port plus valid/ready byte stream, grouped for the serializer.
interface fifo_byte_serializer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_read_enable;
    logic [BYTE_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;

    modport master (
        input  fifo_data_out,
        input  fifo_empty,
        input  out_ready,
        output fifo_read_enable,
        output out_data,
        output out_valid,
        output out_last,
        output busy
    );

    modport slave (
        output fifo_data_out,
        output fifo_empty,
        output out_ready,
        input  fifo_read_enable,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  busy
    );

endinterface

// File: rtl/fifo_byte_serializer.sv
// Pops words from the interconnect FIFO and streams them out as valid/ready beats,
// flagging the final beat of each word.
module fifo_byte_serializer
    import interconnect_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    fifo_byte_serializer_if.master bus
);

    localparam int unsigned Beats = calc_beats(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned CntW  = calc_cnt_width(Beats);
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    serializer_state_t     state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    logic                  handshake;
    logic                  is_last;
    logic                  read_enable;
    logic [CntW-1:0]       beat_idx;
    logic [BYTE_WIDTH-1:0] beat_w [Beats];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        is_last   = (cnt_q == LastCnt);
        handshake = (state_q == SEND) && bus.out_ready;
        // A new pop only when no word is held, or as the held word's last beat leaves.
        read_enable = !rst && !bus.fifo_empty &&
                      ((state_q == IDLE) || (handshake && is_last));

        unique case (state_q)
            IDLE: begin
                if (read_enable) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = SEND;
                word_d  = bus.fifo_data_out;
                cnt_d   = '0;
            end
            SEND: begin
                if (handshake) begin
                    if (!is_last) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        state_d = read_enable ? FETCH : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < Beats; i++) begin
            beat_w[i] = word_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        beat_idx = MSB_FIRST ? (LastCnt - cnt_q) : cnt_q;
    end

    assign bus.fifo_read_enable = read_enable;
    assign bus.out_valid        = (state_q == SEND);
    assign bus.out_last         = (state_q == SEND) && is_last;
    assign bus.out_data         = beat_w[beat_idx];
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench: FIFO model feeds two serializers (LSB- and MSB-first); a scoreboard
// checks every accepted beat against bytes predicted from the words pushed.
module tb_fifo_byte_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_byte_serializer_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) if_l ();
    fifo_byte_serializer_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) if_m ();

    fifo_byte_serializer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_l)
    );

    fifo_byte_serializer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_m)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // FIFO models: a queue each, pushed on request and popped on fifo_read_enable.
    logic [31:0] fifo_l[$];
    logic [31:0] fifo_m[$];
    int          cnt_l = 0;
    int          cnt_m = 0;
    logic        push_l_req = 1'b0;
    logic        push_m_req = 1'b0;
    logic [31:0] push_l_word = '0;
    logic [31:0] push_m_word = '0;

    always @(posedge clk) begin
        if (if_l.fifo_read_enable && cnt_l > 0) if_l.fifo_data_out <= fifo_l.pop_front();
        if (push_l_req) fifo_l.push_back(push_l_word);
        cnt_l <= cnt_l - int'(if_l.fifo_read_enable && cnt_l > 0) + int'(push_l_req);
        if_l.fifo_empty <= (cnt_l - int'(if_l.fifo_read_enable && cnt_l > 0)
                            + int'(push_l_req)) == 0;
    end

    always @(posedge clk) begin
        if (if_m.fifo_read_enable && cnt_m > 0) if_m.fifo_data_out <= fifo_m.pop_front();
        if (push_m_req) fifo_m.push_back(push_m_word);
        cnt_m <= cnt_m - int'(if_m.fifo_read_enable && cnt_m > 0) + int'(push_m_req);
        if_m.fifo_empty <= (cnt_m - int'(if_m.fifo_read_enable && cnt_m > 0)
                            + int'(push_m_req)) == 0;
    end

    // Scoreboards of {last, byte} and event logs (cycle numbers).
    logic [8:0] exp_l[$];
    logic [8:0] exp_m[$];
    int         rd_l[$];
    int         beat_cyc_l[$];
    int         last_cyc_l[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic [31:0] w, input bit msb, input bit to_m);
        logic [31:0] wv;
        int          idx;
        wv = w;
        for (int i = 0; i < 4; i++) begin
            idx = msb ? 3 - i : i;
            if (to_m) exp_m.push_back({(i == 3), wv[idx*8 +: 8]});
            else      exp_l.push_back({(i == 3), wv[idx*8 +: 8]});
        end
    endtask

    // One clock: monitor at the falling edge, return just after the rising edge.
    task automatic step();
        logic [8:0] beat;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (if_l.fifo_read_enable) rd_l.push_back(cyc);
            if (if_l.out_valid && if_l.out_ready) begin
                beat = {if_l.out_last, if_l.out_data};
                beat_cyc_l.push_back(cyc);
                if (if_l.out_last) last_cyc_l.push_back(cyc);
                if (exp_l.size() == 0) chk("lsb_extra_beat", 32'(beat), 32'h1ff);
                else                   chk("lsb_beat", 32'(beat), 32'(exp_l.pop_front()));
            end
            if (if_m.out_valid && if_m.out_ready) begin
                beat = {if_m.out_last, if_m.out_data};
                if (exp_m.size() == 0) chk("msb_extra_beat", 32'(beat), 32'h1ff);
                else                   chk("msb_beat", 32'(beat), 32'(exp_m.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_l(input logic [31:0] w, input bit predict_beats);
        if (predict_beats) predict(w, 1'b0, 1'b0);
        push_l_req  = 1'b1;
        push_l_word = w;
        step();
        push_l_req  = 1'b0;
    endtask

    task automatic push_m(input logic [31:0] w);
        predict(w, 1'b1, 1'b1);
        push_m_req  = 1'b1;
        push_m_word = w;
        step();
        push_m_req  = 1'b0;
    endtask

    task automatic drain(input int bound);
        int i = 0;
        while ((exp_l.size() > 0 || exp_m.size() > 0) && i < bound) begin
            step();
            i++;
        end
        chk("drain_lsb_left", exp_l.size(), 0);
        chk("drain_msb_left", exp_m.size(), 0);
    endtask

    initial begin
        int i;
        rst = 1'b1;
        if_l.out_ready = 1'b0;
        if_m.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset hold with a word waiting in the FIFO.
        push_l(32'h4433_2211, 1'b1);
        repeat (5) begin
            step();
            chk("rst_read_enable", 32'(if_l.fifo_read_enable), 0);
            chk("rst_out_valid", 32'(if_l.out_valid), 0);
            chk("rst_busy", 32'(if_l.busy), 0);
        end
        chk("rst_out_data", 32'(if_l.out_data), 0);

        // Single word with the sink always ready.
        if_l.out_ready = 1'b1;
        rst = 1'b0;
        drain(20);
        chk("single_pops", rd_l.size(), 1);
        chk("single_beats", beat_cyc_l.size(), 4);
        if (rd_l.size() == 1 && beat_cyc_l.size() == 4) begin
            chk("single_first_latency", beat_cyc_l[0] - rd_l[0], 2);
            chk("single_consecutive", beat_cyc_l[3] - beat_cyc_l[0], 3);
        end
        step();
        step();
        chk("single_idle_busy", 32'(if_l.busy), 0);
        chk("single_idle_valid", 32'(if_l.out_valid), 0);

        // Backpressure on the second beat.
        if_l.out_ready = 1'b0;
        push_l(32'h4433_2211, 1'b1);
        i = 0;
        while (!if_l.out_valid && i < 10) begin
            step();
            i++;
        end
        chk("bp_valid_seen", 32'(if_l.out_valid), 1);
        if_l.out_ready = 1'b1;
        step();
        if_l.out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_hold_data", 32'(if_l.out_data), 32'h22);
            chk("bp_hold_valid", 32'(if_l.out_valid), 1);
            chk("bp_hold_last", 32'(if_l.out_last), 0);
        end
        if_l.out_ready = 1'b1;
        drain(20);

        // Back-to-back words: pop coincides with each last-beat handshake.
        rd_l.delete();
        last_cyc_l.delete();
        push_l(32'h0000_0001, 1'b1);
        push_l(32'h0000_0002, 1'b1);
        push_l(32'h0000_0003, 1'b1);
        drain(40);
        chk("b2b_pops", rd_l.size(), 3);
        chk("b2b_lasts", last_cyc_l.size(), 3);
        if (rd_l.size() == 3 && last_cyc_l.size() == 3) begin
            chk("b2b_period_1", rd_l[1] - rd_l[0], 5);
            chk("b2b_period_2", rd_l[2] - rd_l[1], 5);
            chk("b2b_pop_on_last_1", rd_l[1], last_cyc_l[0]);
            chk("b2b_pop_on_last_2", rd_l[2], last_cyc_l[1]);
        end
        step();
        step();
        chk("b2b_no_pop_when_empty", rd_l.size(), 3);
        chk("b2b_idle_busy", 32'(if_l.busy), 0);

        // Most-significant beat first.
        if_m.out_ready = 1'b1;
        push_m(32'hAABB_CCDD);
        drain(20);

        // Reset after two beats discards the rest of the word.
        beat_cyc_l.delete();
        exp_l.push_back({1'b0, 8'h11});
        exp_l.push_back({1'b0, 8'h22});
        push_l(32'h4433_2211, 1'b0);
        i = 0;
        while (beat_cyc_l.size() < 2 && i < 10) begin
            step();
            i++;
        end
        chk("midrst_two_beats", beat_cyc_l.size(), 2);
        rst = 1'b1;
        if_l.out_ready = 1'b0;
        step();
        step();
        chk("midrst_valid", 32'(if_l.out_valid), 0);
        chk("midrst_busy", 32'(if_l.busy), 0);
        chk("midrst_read_enable", 32'(if_l.fifo_read_enable), 0);
        rst = 1'b0;
        rd_l.delete();
        if_l.out_ready = 1'b1;
        push_l(32'h8877_6655, 1'b1);
        drain(20);
        chk("midrst_single_pop", rd_l.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
